// File: rtl/cordic_vec_atan_if.sv
// rtl/cordic_vec_atan_if.sv - custom-instruction handshake bundle for the vectoring CORDIC atan unit
//
// Signals:
//   clk_en  clock enable; 0 freezes all unit state
//   start   load operands and begin (sampled only with clk_en=1)
//   dataa   FP32 y operand
//   datab   FP32 x operand
//   result  FP32 angle in radians, valid while done=1
//   done    level, computation complete
// master drives operands/control, slave is the arithmetic unit.
interface cordic_vec_atan_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    modport master (
        output clk_en, start, dataa, datab,
        input  result, done
    );

    modport slave (
        input  clk_en, start, dataa, datab,
        output result, done
    );
endinterface

// File: rtl/cordic_vec_atan.sv
// rtl/cordic_vec_atan.sv - iterative vectoring-mode CORDIC returning atan(y/x) as FP32
//
// fixed_to_float_q1_20: signed Q1.20 (21 bit) -> FP32, exact (21 significant bits fit in 24).
//   fixed  in  21  signed Q1.20 value
//   fp     out 32  FP32 encoding
//
// cordic_vec_atan: drives y to zero with one micro-rotation per enabled clock,
// accumulating the rotation angle in z.
//   clock  in  rising-edge clock
//   aclr   in  synchronous active-low reset, wins over clk_en
//   bus    slave modport of cordic_vec_atan_if (clk_en, start, dataa=y, datab=x, result, done)

module fixed_to_float_q1_20 (
    input  logic signed [20:0] fixed,
    output logic        [31:0] fp
);
    logic [20:0] mag;
    logic [4:0]  pos;
    logic [43:0] aligned;

    always_comb begin
        mag     = fixed[20] ? 21'(-fixed) : 21'(fixed);
        pos     = 5'd0;
        aligned = 44'd0;
        fp      = 32'd0;
        for (int i = 0; i < 21; i++) begin
            if (mag[i]) pos = 5'(i);
        end
        if (mag != 21'd0) begin
            // Put the leading one at bit 23 so bits 22:0 are the fraction.
            aligned = {23'd0, mag} << (5'd23 - pos);
            fp      = {fixed[20], 8'(pos) + 8'd107, aligned[22:0]};
        end
    end
endmodule

module cordic_vec_atan #(
    parameter int ITER = 16,
    parameter int XYW  = 24
) (
    input  logic              clock,
    input  logic              aclr,
    cordic_vec_atan_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state;
    logic signed [XYW-1:0]  x, y;
    logic signed [20:0]     z;
    logic        [4:0]      idx;

    logic signed [XYW-1:0]  x_shr, y_shr, x_next, y_next, conv_x, conv_y;
    logic signed [20:0]     z_next, angle;

    // FP32 -> signed Q3.20, truncated toward zero. Q value = mantissa24 >> (130 - exp).
    function automatic logic signed [XYW-1:0] fp_to_q(input logic [31:0] f);
        logic [7:0]            e;
        logic [23:0]           mant;
        logic [XYW-2:0]        mag;
        logic signed [XYW-1:0] q;
        e    = f[30:23];
        mant = {1'b1, f[22:0]};
        if (e < 8'd107)
            mag = '0;                       // zero, denormal, or below one Q20 lsb
        else if (e >= 8'd129)
            mag = '1;                       // |v| >= 4 saturates
        else
            mag = (XYW-1)'(mant >> (8'd130 - e));
        q = {1'b0, mag};
        return f[31] ? -q : q;
    endfunction

    // atan(2^-i) in Q1.20
    function automatic logic signed [20:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    atan_lut = 21'h0c90fe;
            5'd1:    atan_lut = 21'h076b1a;
            5'd2:    atan_lut = 21'h03eb6f;
            5'd3:    atan_lut = 21'h01fd5c;
            5'd4:    atan_lut = 21'h00ffab;
            5'd5:    atan_lut = 21'h007ff5;
            5'd6:    atan_lut = 21'h003fff;
            5'd7:    atan_lut = 21'h002000;
            5'd8:    atan_lut = 21'h001000;
            5'd9:    atan_lut = 21'h000800;
            5'd10:   atan_lut = 21'h000400;
            5'd11:   atan_lut = 21'h000200;
            5'd12:   atan_lut = 21'h000100;
            5'd13:   atan_lut = 21'h000080;
            5'd14:   atan_lut = 21'h000040;
            5'd15:   atan_lut = 21'h000020;
            default: atan_lut = 21'h000000;
        endcase
    endfunction

    always_comb begin
        conv_x = fp_to_q(bus.datab);
        conv_y = fp_to_q(bus.dataa);
        x_shr  = x >>> idx;
        y_shr  = y >>> idx;
        angle  = atan_lut(idx);
        // Rotate toward y = 0: the sign of y picks the direction.
        if (!y[XYW-1]) begin
            x_next = x + y_shr;
            y_next = y - x_shr;
            z_next = z + angle;
        end else begin
            x_next = x - y_shr;
            y_next = y + x_shr;
            z_next = z - angle;
        end
    end

    always_ff @(posedge clock) begin
        if (!aclr) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            idx   <= '0;
        end else if (bus.clk_en) begin
            if (bus.start) begin
                // A start restarts from any state, including mid-run.
                x     <= conv_x;
                y     <= conv_y;
                z     <= '0;
                idx   <= '0;
                state <= S_RUN;
            end else if (state == S_RUN) begin
                x   <= x_next;
                y   <= y_next;
                z   <= z_next;
                idx <= idx + 5'd1;
                if (idx == 5'(ITER - 1))
                    state <= S_DONE;
            end
        end
    end

    assign bus.done = (state == S_DONE);

    fixed_to_float_q1_20 u_f2f (
        .fixed (z),
        .fp    (bus.result)
    );
endmodule

// File: tb/tb_cordic_vec_atan.sv
// tb/tb_cordic_vec_atan.sv - scoreboard bench for cordic_vec_atan against a real-arithmetic atan model
module tb_cordic_vec_atan;
    logic clock = 1'b0;
    logic aclr;

    cordic_vec_atan_if bus ();

    cordic_vec_atan dut (
        .clock (clock),
        .aclr  (aclr),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        real angle;
        int  lat;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   start_cyc = 0;

    localparam real TOL = 1.0 / 8192.0;

    function automatic real fp_val(input logic [31:0] f);
        int  e;
        real m;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return f[31] ? -m : m;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input real act, input real req);
        real d;
        checks++;
        d = act - req;
        if (d < 0.0) d = -d;
        if (d > TOL) begin
            errors++;
            $display("FAIL %s: got %f expected %f", name, act, req);
        end
    endtask

    // Issue a start on the next edge; any outstanding transaction is aborted by it.
    task automatic do_start(input logic [31:0] ya, input logic [31:0] xb, input int lat);
        exp_t e;
        @(negedge clock);
        bus.dataa = ya;
        bus.datab = xb;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        start_cyc = cyc;
        sb_q.delete();
        e.angle = $atan(fp_val(ya) / fp_val(xb));
        e.lat   = lat;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clock);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
            sb_q.delete();
        end
    endtask

    initial begin
        aclr       = 1'b0;
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.dataa  = 32'd0;
        bus.datab  = 32'd0;

        fork
            begin : monitor
                logic prev;
                exp_t e;
                int   lat;
                prev = 1'b0;
                forever begin
                    @(negedge clock);
                    if (bus.done && !prev) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
                        end else begin
                            e   = sb_q.pop_front();
                            lat = cyc - start_cyc + 1;
                            check_eq("latency", 32'(lat), 32'(e.lat));
                            check_near("angle", fp_val(bus.result), e.angle);
                        end
                    end
                    prev = bus.done;
                end
            end
        join_none

        repeat (3) @(posedge clock);
        #1 aclr = 1'b1;
        @(negedge clock);
        check_eq("reset_done", 32'(bus.done), 32'd0);
        check_eq("reset_result", bus.result, 32'h0);

        // 45 degrees
        do_start(32'h3F000000, 32'h3F000000, 17);
        wait_done("case1");

        // negative angle
        do_start(32'hBE800000, 32'h3F000000, 17);
        wait_done("case2");
        @(negedge clock);
        check_eq("case2_sign", 32'(bus.result[31]), 32'd1);

        // y = 0, then hold
        do_start(32'h00000000, 32'h3F400000, 17);
        wait_done("case3");
        repeat (10) begin
            @(negedge clock);
            check_eq("hold_done", 32'(bus.done), 32'd1);
            check_near("hold_result", fp_val(bus.result), 0.0);
        end

        // stall for 5 cycles at idx=7
        do_start(32'h3F000000, 32'h3F000000, 22);
        repeat (7) @(posedge clock);
        #1 bus.clk_en = 1'b0;
        repeat (5) @(posedge clock);
        #1 bus.clk_en = 1'b1;
        wait_done("stall");

        // restart at idx=9 with case 2 operands
        do_start(32'h3F000000, 32'h3F000000, 17);
        repeat (9) @(posedge clock);
        do_start(32'hBE800000, 32'h3F000000, 17);
        wait_done("restart");

        // reset at idx=5 aborts; no done afterwards
        do_start(32'h3F000000, 32'h3F000000, 17);
        repeat (5) @(posedge clock);
        #1 aclr = 1'b0;
        @(posedge clock);
        #1 aclr = 1'b1;
        sb_q.delete();
        @(negedge clock);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_result", bus.result, 32'h0);
        repeat (30) @(posedge clock);

        // random in-domain operands: x in [1/16, 1), |y| <= x
        for (int n = 0; n < 24; n++) begin
            int unsigned ex, ey, mx, my;
            logic        sy;
            ex = $urandom_range(126, 123);
            mx = $urandom & 32'h7fffff;
            ey = ex - $urandom_range(5, 0);
            my = (ey == ex) ? $urandom_range(mx, 0) : ($urandom & 32'h7fffff);
            sy = 1'($urandom);
            do_start({sy, 8'(ey), 23'(my)}, {1'b0, 8'(ex), 23'(mx)}, 17);
            wait_done("random");
        end

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cordic_vec_atan.md
Name: cordic_vec_atan

Overview:
- Vectoring-mode CORDIC: the inverse direction of the team's rotation-mode cosine unit.
- Drives y to zero to return atan(y/x) as FP32.
- Packaged as a multi-cycle custom instruction: dataa = y, datab = x. Same start/done/clk_en contract as the cosine unit.
- Iterative, one micro-rotation per enabled clock. Shares the 21-bit Q1.20 angle format and arctan LUT with the cosine unit.

Parameters:
- ITER, 16, number of micro-rotations; fixed at 16 because the LUT has 16 entries.
- XYW, 24, internal x/y width (signed Q3.20); covers CORDIC gain 1.647 × √2.

Ports:
- clock  in  1  system clock, rising edge.
- aclr  in  1  reset, synchronous, active-low (0 = reset).
- clk_en  in  1  clock enable; when 0, all state is frozen.
- start  in  1  load operands and begin; sampled only when clk_en=1.
- dataa  in  32  FP32 y operand.
- datab  in  32  FP32 x operand.
- result  out  32  FP32 angle in radians; valid while done=1.
- done  out  1  computation complete, level.

Behaviour:
- Domain: x>0, |y|≤x, |x|<1. Result lies in [-π/4, π/4]. Outside the domain, result is unspecified but done still asserts on schedule.
- Operand conversion (combinational, internal):
  - FP32 → signed Q3.20 (24 bit), truncated toward zero, sign applied as two's complement.
  - Biased exponent < 107 (|v| < 2^-20), zero, or denormal → 0.
  - Exponent ≥ 129 (|v| ≥ 4) saturates to ±(2^23−1).
- Angle LUT, Q1.20, index 0..15: 0c90fe, 076b1a, 03eb6f, 01fd5c, 00ffab, 007ff5, 003fff, 002000, 001000, 000800, 000400, 000200, 000100, 000080, 000040, 000020 (hex). Index 16 and above read as 0.
- Registers: x, y (24 bit signed), z (21 bit signed Q1.20), idx (5 bit), state.
- FSM states: IDLE, RUN, DONE.
  - Reset (aclr=0 at a clock edge; takes effect regardless of clk_en): state=IDLE, x=y=z=0, idx=0. This applies mid-operation too, aborting any computation.
  - clk_en=0: hold everything, including done.
  - clk_en=1 and start=1 (any state, including mid-RUN): x=conv(datab), y=conv(dataa), z=0, idx=0, state=RUN. Start has priority over iteration.
  - RUN, clk_en=1, start=0, y≥0: x=x+(y>>>idx), y=y−(x>>>idx), z=z+LUT[idx], idx=idx+1. All updates use old values; shifts are arithmetic.
  - RUN, clk_en=1, start=0, y<0: x=x−(y>>>idx), y=y+(x>>>idx), z=z−LUT[idx], idx=idx+1.
  - RUN with idx==15 on an iterating edge: perform the final iteration and go to DONE.
  - DONE and IDLE without start: hold.
- Arithmetic: z add/sub wraps at 21 bits; no overflow within the domain. x/y add/sub is 24 bit.
- Outputs:
  - done = (state==DONE), registered-state decode; 0 in IDLE and RUN.
  - result = fixed_to_float(z), via the existing 21-bit unit instantiated as-is, combinational from z.
  - After reset, result = 0x00000000.
- Latency: the start edge plus 16 enabled edges, so done=1 after the 17th enabled edge counting the start edge. Stalled cycles add one each.
- Accuracy: |result − atan(y/x)| ≤ 2^-13 over the domain.

Test Plan:
- Reset, then y=0x3F000000 (0.5), x=0x3F000000, start 1 cycle → done=1 exactly 17 edges after start; result ≈ 0x3F490FDB (0.785398) ±2^-13; done=0 on edges 1–16.
- y=0xBE800000 (−0.25), x=0x3F000000 (0.5) → result ≈ −0.463648 (0xBEED6338) ±2^-13; sign bit=1.
- y=0x00000000, x=0x3F400000 (0.75) → |result| ≤ 2^-13; then hold 10 extra cycles → done and result stable.
- Case 1 with clk_en deasserted for 5 cycles at idx=7 → x/y/z/idx frozen during the stall; done at edge 22; same result as case 1.
- Start case 1, re-assert start with case 2 operands at idx=9 → restart; done 17 edges after the second start; case 2 result; no early done.
- aclr=0 at idx=5 for one edge → done=0, result=0x00000000, IDLE; no done without a new start over 30 cycles.
